uart_tx_pkt_arbiter: RTL

- Shares the single `uart_tx` byte transmitter between two byte-stream sources: s0 is the TRNG random-data path and s1 is the status/debug path.
- Grants the UART to one source for a whole packet, using round-robin arbitration.
- Wraps each packet as: channel header byte, payload bytes, XOR checksum byte.
- Sequences `uart_tx` through its `tx_start`/`tx_busy` handshake, and closes a stalled packet after a timeout.

---
 rtl/uart_tx_pkt_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_pkt_arbiter.sv
// Round-robin packet arbiter that shares one uart_tx between two byte streams.
// Each packet goes out as header, payload, then an XOR checksum of the payload.
module uart_tx_pkt_arbiter #(
    parameter logic [7:0] HDR0           = 8'hA5,
    parameter logic [7:0] HDR1           = 8'h5A,
    parameter int         TIMEOUT_CYCLES = 1250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       pkt_done,
    output logic       timeout_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR     = 3'd1;
    localparam logic [2:0] GET     = 3'd2;
    localparam logic [2:0] SEND    = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;
    localparam logic [2:0] WAIT_LO = 3'd5;
    localparam logic [2:0] CSUM    = 3'd6;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       ret_state;
    logic [7:0]       csum;
    logic [CNT_W-1:0] idle_cnt;
    logic             last_s1;

    logic       sel_valid;
    logic       sel_last;
    logic [7:0] sel_data;
    logic       pick_s1;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        sel_valid = s0_valid;
        sel_last  = s0_last;
        sel_data  = s0_data;
        if (grant[1]) begin
            sel_valid = s1_valid;
            sel_last  = s1_last;
            sel_data  = s1_data;
        end
    end

    // On a tie the source that was not served last wins.
    assign pick_s1  = s1_valid && (!s0_valid || !last_s1);

    assign s0_ready = (state == GET) && grant[0];
    assign s1_ready = (state == GET) && grant[1];
    assign tx_start = (state == HDR) || (state == SEND);

    // NOTE: all state below uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ret_state   <= IDLE;
            csum        <= 8'h00;
            idle_cnt    <= '0;
            last_s1     <= 1'b1;
            tx_data     <= 8'h00;
            grant       <= 2'b00;
            pkt_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pkt_done    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if ((s0_valid || s1_valid) && !tx_busy) begin
                        grant     <= pick_s1 ? 2'b10 : 2'b01;
                        tx_data   <= pick_s1 ? HDR1 : HDR0;
                        csum      <= 8'h00;
                        ret_state <= GET;
                        state     <= HDR;
                    end
                end
                HDR, SEND: state <= WAIT_HI;
                WAIT_HI: begin
                    if (tx_busy) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        state    <= ret_state;
                        idle_cnt <= '0;
                        if (ret_state == IDLE) begin
                            pkt_done <= 1'b1;
                            grant    <= 2'b00;
                            last_s1  <= grant[1];
                        end
                    end
                end
                GET: begin
                    if (sel_valid) begin
                        tx_data   <= sel_data;
                        csum      <= csum ^ sel_data;
                        idle_cnt  <= '0;
                        ret_state <= sel_last ? CSUM : GET;
                        state     <= SEND;
                    end else if (idle_cnt == CNT_LAST) begin
                        // Stalled source: close the packet with an inverted checksum.
                        timeout_err <= 1'b1;
                        tx_data     <= csum ^ 8'hFF;
                        ret_state   <= IDLE;
                        state       <= SEND;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                CSUM: begin
                    tx_data   <= csum;
                    ret_state <= IDLE;
                    state     <= SEND;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
